// File: rtl/if_id_pkg.sv
// Shared instruction-field layout and stage types for the IF/ID pipeline register.
package if_id_pkg;

  localparam int INST_W = 32;

  localparam int OP_LSB  = 26;
  localparam int OP_W    = 6;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SA_LSB  = 6;
  localparam int REG_W   = 5;
  localparam int FN_LSB  = 0;
  localparam int FN_W    = 6;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;
  localparam int TGT_LSB = 0;
  localparam int TGT_W   = 26;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  sa;
    logic [FN_W-1:0]   fn;
    logic [INST_W-1:0] imm;
    logic [TGT_W-1:0]  target;
  } lane_t;

  localparam int LANE_W = $bits(lane_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

  function automatic logic [INST_W-1:0] ext_imm(input logic [IMM_W-1:0] imm, input logic sext);
    return sext ? {{(INST_W-IMM_W){imm[IMM_W-1]}}, imm} : {{(INST_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/if_id_lane_decode.sv
// Combinational split of one instruction word into its fields; a disabled lane decodes to all zeros.
module if_id_lane_decode
  import if_id_pkg::*;
#(
  parameter int IMM_SEXT = 1
) (
  input  logic [INST_W-1:0] inst,
  input  logic              en,
  output lane_t             fields
);

  always_comb begin
    fields = '0;
    if (en) begin
      fields.opcode = inst[OP_LSB +: OP_W];
      fields.rs     = inst[RS_LSB +: REG_W];
      fields.rt     = inst[RT_LSB +: REG_W];
      fields.rd     = inst[RD_LSB +: REG_W];
      fields.sa     = inst[SA_LSB +: REG_W];
      fields.fn     = inst[FN_LSB +: FN_W];
      fields.imm    = ext_imm(inst[IMM_LSB +: IMM_W], IMM_SEXT != 0);
      fields.target = inst[TGT_LSB +: TGT_W];
    end
  end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: decodes a fetch bundle per lane and holds it for the decode stage, 1-cycle latency.
// Define IF_ID_SKID_EN for a 2-entry skid buffer with registered if_ready; default is a single stage.
module if_id_pipe
  import if_id_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int ADDR_W   = 32,
  parameter int IMM_SEXT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [ADDR_W-1:0]         if_pc,
  input  logic [LANES*INST_W-1:0]   if_inst,
  input  logic [LANES-1:0]          if_lane_mask,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [ADDR_W-1:0]         id_pc,
  output logic [LANES-1:0]          id_lane_mask,
  output logic [LANES*OP_W-1:0]     id_opcode,
  output logic [LANES*REG_W-1:0]    id_rs,
  output logic [LANES*REG_W-1:0]    id_rt,
  output logic [LANES*REG_W-1:0]    id_rd,
  output logic [LANES*REG_W-1:0]    id_sa,
  output logic [LANES*FN_W-1:0]     id_fn,
  output logic [LANES*INST_W-1:0]   id_imm,
  output logic [LANES*TGT_W-1:0]    id_target
);

  localparam int ENT_W = ADDR_W + LANES + LANES*LANE_W;

  lane_t [LANES-1:0] dec;
  lane_t [LANES-1:0] out_lane;
  logic  [ENT_W-1:0] in_ent;
  logic  [ENT_W-1:0] main_q;
  logic              accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if_id_lane_decode #(.IMM_SEXT(IMM_SEXT)) u_dec (
      .inst   (if_inst[i*INST_W +: INST_W]),
      .en     (if_lane_mask[i]),
      .fields (dec[i])
    );
    assign id_opcode[i*OP_W +: OP_W]     = out_lane[i].opcode;
    assign id_rs[i*REG_W +: REG_W]       = out_lane[i].rs;
    assign id_rt[i*REG_W +: REG_W]       = out_lane[i].rt;
    assign id_rd[i*REG_W +: REG_W]       = out_lane[i].rd;
    assign id_sa[i*REG_W +: REG_W]       = out_lane[i].sa;
    assign id_fn[i*FN_W +: FN_W]         = out_lane[i].fn;
    assign id_imm[i*INST_W +: INST_W]    = out_lane[i].imm;
    assign id_target[i*TGT_W +: TGT_W]   = out_lane[i].target;
  end

  assign in_ent = {if_pc, if_lane_mask, dec};
  assign {id_pc, id_lane_mask, out_lane} = main_q;
  assign accept = if_valid && if_ready;

`ifdef IF_ID_SKID_EN
  skid_state_t      state_q, state_d;
  logic [ENT_W-1:0] skid_q;
  logic             rdy_q;
  logic             load_main, load_skid, pop_skid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // A beat arriving while the output is stalled parks in the skid entry.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d   = FULL;
          load_main = 1'b1;
        end
        FULL: begin
          if (accept && id_ready) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end else if (id_ready) begin
            state_d = EMPTY;
          end
        end
        SKID: if (id_ready) begin
          state_d  = FULL;
          pop_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_skid) skid_q <= in_ent;
      if (pop_skid)       main_q <= skid_q;
      else if (load_main) main_q <= in_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdy_q <= 1'b1;
    else     rdy_q <= (state_d != SKID);
  end

  assign id_valid = (state_q != EMPTY);
  assign if_ready = rdy_q && !rst;
`else
  logic vld_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q  <= 1'b0;
      main_q <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      main_q <= in_ent;
    end else if (id_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign id_valid = vld_q;
  assign if_ready = !rst && (!vld_q || id_ready);
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Randomized bench for if_id_pipe against a queue-based model of the stage contents.
module tb_if_id_pipe;

  localparam int LANES    = 2;
  localparam int ADDR_W   = 32;
  localparam int IMM_SEXT = 1;
  localparam int BW       = ADDR_W + LANES + LANES*90;

  logic                clk = 1'b0;
  logic                rst, flush, if_valid, if_ready, id_valid, id_ready;
  logic [ADDR_W-1:0]   if_pc, id_pc;
  logic [LANES*32-1:0] if_inst;
  logic [LANES-1:0]    if_lane_mask, id_lane_mask;
  logic [LANES*6-1:0]  id_opcode, id_fn;
  logic [LANES*5-1:0]  id_rs, id_rt, id_rd, id_sa;
  logic [LANES*32-1:0] id_imm;
  logic [LANES*26-1:0] id_target;

  logic [BW-1:0] q[$];
  int n_chk = 0, n_pass = 0;
  int pushed = 0, popped = 0, dropped = 0;

  if_id_pipe #(.LANES(LANES), .ADDR_W(ADDR_W), .IMM_SEXT(IMM_SEXT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_lane_mask(if_lane_mask),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_lane_mask(id_lane_mask),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_sa(id_sa), .id_fn(id_fn), .id_imm(id_imm), .id_target(id_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] dut_bundle();
    return {id_pc, id_lane_mask, id_opcode, id_rs, id_rt, id_rd, id_sa, id_fn, id_imm, id_target};
  endfunction

  // Expected decode computed straight from the instruction format.
  function automatic logic [BW-1:0] exp_bundle(input logic [31:0] pc, input logic [63:0] inst,
                                               input logic [1:0] m);
    logic [11:0] op = '0, fn = '0;
    logic [9:0]  rs = '0, rt = '0, rd = '0, sa = '0;
    logic [63:0] imm = '0;
    logic [51:0] tg = '0;
    logic [31:0] w, lo;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        w = inst[32*i +: 32];
        lo = w & 32'hFFFF;
        op[6*i +: 6]  = 6'(w >> 26);
        rs[5*i +: 5]  = 5'(w >> 21);
        rt[5*i +: 5]  = 5'(w >> 16);
        rd[5*i +: 5]  = 5'(w >> 11);
        sa[5*i +: 5]  = 5'(w >> 6);
        fn[6*i +: 6]  = 6'(w);
        imm[32*i +: 32] = (IMM_SEXT != 0 && lo >= 32'h8000) ? lo - 32'h10000 : lo;
        tg[26*i +: 26] = 26'(w);
      end
    end
    return {pc, m, op, rs, rt, rd, sa, fn, imm, tg};
  endfunction

  // One clock: called at a negedge, drives inputs, checks, updates the model, returns at next negedge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [63:0] inst,
                       input logic [1:0] m, input logic rdy, input logic fl, output bit acc);
    bit exp_rdy, fire_dn, fire_up;
    if_valid = v; if_pc = pc; if_inst = inst; if_lane_mask = m; id_ready = rdy; flush = fl;
    #1;
`ifdef IF_ID_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || rdy;
`endif
    check("id_valid", id_valid, q.size() != 0);
    check("if_ready", if_ready, exp_rdy);
    if (q.size() != 0) check("bundle", dut_bundle(), q[0]);
    fire_dn = (q.size() != 0) && rdy;
    fire_up = v && exp_rdy;
    acc = fire_up && !fl;
    if (fl) begin
      dropped += q.size();
      q.delete();
    end else begin
      if (fire_dn) begin void'(q.pop_front()); popped++; end
      if (fire_up) begin q.push_back(exp_bundle(pc, inst, m)); pushed++; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; if_valid = 1'b1; id_ready = rdy; flush = 1'b0;
    #1;
    check("rst_if_ready", if_ready, 0);
    @(negedge clk);
    check("rst_id_valid", id_valid, 0);
    check("rst_outputs", dut_bundle(), 0);
    dropped += q.size();
    q.delete();
    rst = 1'b0; if_valid = 1'b0;
    #1;
    check("post_rst_if_ready", if_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int k;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_inst = '0; if_lane_mask = '0;
    do_reset(1'b0);
    @(negedge clk);

    // Basic two-lane decode.
    cycle(1, 32'h100, {32'h2401FFFF, 32'h8C220004}, 2'b11, 1, 0, acc);
    check("dec_valid", id_valid, 1);
    check("dec_op0", id_opcode[5:0], 6'h23);
    check("dec_rs0", id_rs[4:0], 5'd1);
    check("dec_rt0", id_rt[4:0], 5'd2);
    check("dec_imm0", id_imm[31:0], 32'h4);
    check("dec_imm1", id_imm[63:32], IMM_SEXT != 0 ? 32'hFFFFFFFF : 32'h0000FFFF);
    repeat (2) cycle(0, 0, 0, 0, 1, 0, acc);

    // Eight bundles against a toggling consumer.
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      cycle(1, 32'h200 + 32'(k*4), {$urandom, $urandom}, 2'($urandom), (c % 2) == 0, 0, acc);
      if (acc) k++;
    end
    check("stream8_accepted", k, 8);
    repeat (4) cycle(0, 0, 0, 0, 1, 0, acc);

    // Back-to-back beats into a stalled stage.
    for (int c = 0; c < 3; c++) cycle(1, 32'h400 + 32'(c*4), {$urandom, $urandom}, 2'b11, 0, 0, acc);
    check("stalled_if_ready", if_ready, 0);
    repeat (4) cycle(0, 0, 0, 0, 1, 0, acc);

    // Flush collides with an upstream beat.
    cycle(1, 32'h500, {$urandom, $urandom}, 2'b11, 0, 0, acc);
    cycle(1, 32'h504, {$urandom, $urandom}, 2'b11, 0, 1, acc);
    check("flush_id_valid", id_valid, 0);
    repeat (2) cycle(0, 0, 0, 0, 1, 0, acc);

    // Masked-off lane must decode to zero.
    cycle(1, 32'h600, {32'hFFFFFFFF, $urandom}, 2'b01, 0, 0, acc);
    check("mask_out", id_lane_mask, 2'b01);
    check("lane1_zero", {id_opcode[11:6], id_rs[9:5], id_rt[9:5], id_rd[9:5], id_sa[9:5],
                         id_fn[11:6], id_imm[63:32], id_target[51:26]}, 0);
    cycle(0, 0, 0, 0, 1, 0, acc);

    // Reset while stalled with the stage filled.
    for (int c = 0; c < 3; c++) cycle(1, 32'h700 + 32'(c*4), {$urandom, $urandom}, 2'b11, 0, 0, acc);
    do_reset(1'b0);
    @(negedge clk);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'($urandom));
        @(negedge clk);
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom}, 2'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, acc);
      end
    end
    repeat (4) cycle(0, 0, 0, 0, 1, 0, acc);
    check("drain_empty", q.size(), 0);
    check("conserve", popped + dropped, pushed);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
